hash_function_shared_pipe: RTL and testbench
============================================

# hash_function_shared_pipe

Pipelined, runtime-configurable shared-EVA hash unit for the vanilla core's remote-load/store path. It converts a tile-group shared EVA into destination tile X/Y coordinates and a local word offset. Tile-group dimensions and origin come from a programmable config register rather than compile-time widths. Requests pass through a 2-stage valid/ready pipeline with full backpressure, an error flag, and saturating statistics counters.

## Interface
- width_p, 32: shared EVA width.
- x_cord_width_p, 7: output X coordinate width.
- y_cord_width_p, 7: output Y coordinate width.
- tg_log_width_p, 3: width of the per-dimension log2 tile-group size fields.
- hash_width_p, 4: stripe (hash) field width.
- addr_width_p, 16: local word-offset output width.
- max_local_offset_width_p, 12: largest legal hash value.
- count_width_p, 16: statistics counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- cfg_v_i  in  1  config write strobe.
- cfg_ready_o  out  1  config write accepted when high.
- cfg_tg_x_log_i  in  tg_log_width_p  log2 tile-group X size.
- cfg_tg_y_log_i  in  tg_log_width_p  log2 tile-group Y size.
- cfg_origin_x_i  in  x_cord_width_p  tile-group origin X.
- cfg_origin_y_i  in  y_cord_width_p  tile-group origin Y.
- v_i  in  1  request valid.
- ready_o  out  1  request accepted when v_i & ready_o.
- eva_i  in  width_p  shared EVA.
- hash_i  in  hash_width_p  stripe size, in bits.
- v_o  out  1  result valid.
- ready_i  in  1  consumer accepts result when v_o & ready_i.
- x_o  out  x_cord_width_p  destination X.
- y_o  out  y_cord_width_p  destination Y.
- addr_o  out  addr_width_p  local word offset.
- err_o  out  1  illegal request; x_o, y_o and addr_o are all 0.
- req_count_o  out  count_width_p  accepted requests, saturating.
- err_count_o  out  count_width_p  erroring requests, saturating.

## Operation
Field definitions, with h = hash, tx = tg_x_log, ty = tg_y_log:
- Stripe field: eva[h-1:0] becomes addr[h-1:0].
- X field: eva[h +: tx].
- Y field: eva[h+tx +: ty].
- Upper field: eva >> (h+tx+ty), placed at addr[addr_width_p-1:h].
- Fields are zero-extended, then truncated to the output widths.
- A field of width 0 contributes 0.

Outputs:
- x_o = (origin_x + X field) mod 2^x_cord_width_p.
- y_o = (origin_y + Y field) mod 2^y_cord_width_p.

Error condition:
- err = (h > max_local_offset_width_p) | (h+tx+ty > width_p).
- On error: x_o, y_o and addr_o are 0; err_o = 1; the result is still delivered in order.

Pipeline stages:
- S1 captures the request and extracts the fields using the current config.
- S2 adds the origin and registers the outputs.
- A single enable en = ~s2_v | ready_i advances both stages.
- ready_o = en & ~(cfg_v_i & cfg_ready_o).

Config register:
- cfg_ready_o = ~s1_v & ~s2_v.
- A write happens when cfg_v_i & cfg_ready_o, and takes effect at the clock edge.
- A config write has priority over a request: ready_o is 0 in that cycle.
- In-flight requests never see a config change.

Counters:
- req_count_o increments on each request handshake.
- err_count_o increments when an erroring request enters S1.
- Both counters saturate at all-ones.

## Timing
- Reset (asynchronous, applies immediately):
  - s1_v, s2_v, v_o, err_o = 0.
  - x_o, y_o, addr_o = 0.
  - Config fields all 0.
  - Both counters 0.
  - ready_o = 1 and cfg_ready_o = 1, once reset is deasserted and no config write is pending.
- Latency: a request handshaked in cycle N appears on v_o in cycle N+2 if ready_i stayed high.
- Throughput: 1 request per cycle.
- Backpressure:
  - With v_o=1 and ready_i=0, S1 and S2 both hold and ready_o=0.
  - Outputs stay stable while v_o=1 and ready_i=0.
- Drain: once ready_i rises, S2 pops, S1 moves to S2, and a new request is accepted in the same cycle.
- Reset mid-operation: in-flight requests are discarded; nothing is replayed.

## Test plan
- Basic translate:
  - Config tx=2, ty=1, origin=(4,2); hash=2, eva=0x000000B7.
  - Required: x_o=5, y_o=3, addr_o=0x0017, err_o=0, 2 cycles after the handshake.
- Streaming:
  - 8 back-to-back requests with ready_i=1.
  - Required: v_o high for 8 consecutive cycles starting 2 cycles after the first handshake, results in order, req_count_o=8.
- Backpressure:
  - Hold ready_i=0 for 5 cycles mid-stream.
  - Required: ready_o=0, outputs frozen, no loss or duplication once ready_i returns high.
- Error:
  - hash=13 (greater than 12).
  - Required: err_o=1, x_o=y_o=addr_o=0, err_count_o increments, the next legal request is correct.
- Config ordering:
  - Assert cfg_v_i while the pipeline is occupied.
  - Required: cfg_ready_o=0 until drained, then the write applies; a same-cycle v_i sees ready_o=0.
- Wrap and saturation:
  - origin_x=127, X field=2: required x_o=1.
  - Force the counters to all-ones: required they hold at all-ones.
  - Async reset mid-stream: required v_o drops immediately.

Source files
------------

// File: rtl/hash_function_shared_pipe.sv
// hash_function_shared_pipe
//
// Purpose: converts a tile-group shared EVA into a destination tile X/Y
// coordinate and a local word offset. The tile-group shape (log2 X/Y size)
// and origin live in a runtime-writable config register. Requests flow
// through a two-stage valid/ready pipeline:
//   S1 - captures the request and slices the EVA into its fields
//   S2 - adds the tile-group origin and holds the registered result
// Both stages advance on a single enable, so backpressure on the output
// freezes the whole pipe.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   cfg_v_i / cfg_ready_o config write strobe / write accepted
//   cfg_tg_x_log_i        log2 tile-group X size
//   cfg_tg_y_log_i        log2 tile-group Y size
//   cfg_origin_x_i/_y_i   tile-group origin
//   v_i / ready_o         request handshake
//   eva_i, hash_i         shared EVA and stripe width in bits
//   v_o / ready_i         result handshake
//   x_o, y_o, addr_o      destination tile and local word offset
//   err_o                 illegal request (x_o, y_o, addr_o forced to 0)
//   req_count_o           accepted requests, saturating
//   err_count_o           erroring requests, saturating
module hash_function_shared_pipe #(
  parameter int width_p                  = 32,
  parameter int x_cord_width_p           = 7,
  parameter int y_cord_width_p           = 7,
  parameter int tg_log_width_p           = 3,
  parameter int hash_width_p             = 4,
  parameter int addr_width_p             = 16,
  parameter int max_local_offset_width_p = 12,
  parameter int count_width_p            = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cfg_v_i,
  output logic                      cfg_ready_o,
  input  logic [tg_log_width_p-1:0] cfg_tg_x_log_i,
  input  logic [tg_log_width_p-1:0] cfg_tg_y_log_i,
  input  logic [x_cord_width_p-1:0] cfg_origin_x_i,
  input  logic [y_cord_width_p-1:0] cfg_origin_y_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [width_p-1:0]        eva_i,
  input  logic [hash_width_p-1:0]   hash_i,
  output logic                      v_o,
  input  logic                      ready_i,
  output logic [x_cord_width_p-1:0] x_o,
  output logic [y_cord_width_p-1:0] y_o,
  output logic [addr_width_p-1:0]   addr_o,
  output logic                      err_o,
  output logic [count_width_p-1:0]  req_count_o,
  output logic [count_width_p-1:0]  err_count_o
);

  // Working width for the offset assembly: wide enough for both the EVA
  // and the offset output so the upper field is never clipped early.
  localparam int ext_w_lp = (width_p > addr_width_p) ? width_p : addr_width_p;

  // Config register
  logic [tg_log_width_p-1:0] cfg_tg_x_log_reg;
  logic [tg_log_width_p-1:0] cfg_tg_y_log_reg;
  logic [x_cord_width_p-1:0] cfg_origin_x_reg;
  logic [y_cord_width_p-1:0] cfg_origin_y_reg;

  // Stage 1
  logic                      s1_v_reg;
  logic                      s1_err_reg;
  logic [x_cord_width_p-1:0] s1_x_reg;
  logic [y_cord_width_p-1:0] s1_y_reg;
  logic [addr_width_p-1:0]   s1_addr_reg;

  // Stage 2 (drives the outputs directly)
  logic                      s2_v_reg;
  logic                      s2_err_reg;
  logic [x_cord_width_p-1:0] s2_x_reg;
  logic [y_cord_width_p-1:0] s2_y_reg;
  logic [addr_width_p-1:0]   s2_addr_reg;

  logic [count_width_p-1:0]  req_count_reg;
  logic [count_width_p-1:0]  err_count_reg;

  // Handshake control
  logic en;
  logic cfg_fire;
  logic req_fire;

  // Config may only change with the pipe empty, so requests in flight
  // always finish under the config they were sliced with.
  assign cfg_ready_o = ~s1_v_reg & ~s2_v_reg;
  assign cfg_fire    = cfg_v_i & cfg_ready_o;
  assign en          = ~s2_v_reg | ready_i;
  // A config write wins the cycle; the request waits.
  assign ready_o     = en & ~cfg_fire;
  assign req_fire    = v_i & ready_o;

  // Mask of the low n bits; a shift of n >= width_p leaves all ones.
  function automatic logic [width_p-1:0] low_mask(input logic [31:0] n);
    low_mask = ~({width_p{1'b1}} << n);
  endfunction

  // Field extraction for the incoming request
  logic [31:0]           hash_amt;
  logic [31:0]           x_shift;
  logic [31:0]           upper_shift;
  logic [width_p-1:0]    x_field;
  logic [width_p-1:0]    y_field;
  logic [width_p-1:0]    stripe_field;
  logic [ext_w_lp-1:0]   upper_ext;
  logic [ext_w_lp-1:0]   offset_ext;
  logic                  req_err;

  always_comb begin
    hash_amt     = 32'(hash_i);
    x_shift      = hash_amt + 32'(cfg_tg_x_log_reg);
    upper_shift  = x_shift + 32'(cfg_tg_y_log_reg);
    x_field      = (eva_i >> hash_amt) & low_mask(32'(cfg_tg_x_log_reg));
    y_field      = (eva_i >> x_shift)  & low_mask(32'(cfg_tg_y_log_reg));
    stripe_field = eva_i & low_mask(hash_amt);
    upper_ext    = ext_w_lp'(eva_i >> upper_shift);
    offset_ext   = (upper_ext << hash_amt) | ext_w_lp'(stripe_field);
    req_err      = (hash_amt > 32'(max_local_offset_width_p)) |
                   (upper_shift > 32'(width_p));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cfg_tg_x_log_reg <= '0;
      cfg_tg_y_log_reg <= '0;
      cfg_origin_x_reg <= '0;
      cfg_origin_y_reg <= '0;
    end else if (cfg_fire) begin
      cfg_tg_x_log_reg <= cfg_tg_x_log_i;
      cfg_tg_y_log_reg <= cfg_tg_y_log_i;
      cfg_origin_x_reg <= cfg_origin_x_i;
      cfg_origin_y_reg <= cfg_origin_y_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_reg    <= 1'b0;
      s1_err_reg  <= 1'b0;
      s1_x_reg    <= '0;
      s1_y_reg    <= '0;
      s1_addr_reg <= '0;
    end else if (en) begin
      s1_v_reg <= req_fire;
      if (req_fire) begin
        s1_err_reg  <= req_err;
        s1_x_reg    <= x_cord_width_p'(x_field);
        s1_y_reg    <= y_cord_width_p'(y_field);
        s1_addr_reg <= addr_width_p'(offset_ext);
      end
    end
  end

  // The origin is read from the live config: it cannot change while S1
  // holds a request, so this is the same config the fields were cut with.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s2_v_reg    <= 1'b0;
      s2_err_reg  <= 1'b0;
      s2_x_reg    <= '0;
      s2_y_reg    <= '0;
      s2_addr_reg <= '0;
    end else if (en) begin
      s2_v_reg <= s1_v_reg;
      if (s1_v_reg) begin
        s2_err_reg  <= s1_err_reg;
        s2_x_reg    <= s1_err_reg ? '0 : cfg_origin_x_reg + s1_x_reg;
        s2_y_reg    <= s1_err_reg ? '0 : cfg_origin_y_reg + s1_y_reg;
        s2_addr_reg <= s1_err_reg ? '0 : s1_addr_reg;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_count_reg <= '0;
      err_count_reg <= '0;
    end else begin
      if (req_fire && (req_count_reg != '1))
        req_count_reg <= req_count_reg + count_width_p'(1);
      if (req_fire && req_err && (err_count_reg != '1))
        err_count_reg <= err_count_reg + count_width_p'(1);
    end
  end

  assign v_o         = s2_v_reg;
  assign err_o       = s2_err_reg;
  assign x_o         = s2_x_reg;
  assign y_o         = s2_y_reg;
  assign addr_o      = s2_addr_reg;
  assign req_count_o = req_count_reg;
  assign err_count_o = err_count_reg;

endmodule

// File: tb/tb_hash_function_shared_pipe.sv
// Directed testbench for hash_function_shared_pipe. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge. The counters are
// built 5 bits wide here so that saturation is reachable in a short run.
module tb_hash_function_shared_pipe;

  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          cfg_v_i;
  logic          cfg_ready_o;
  logic [2:0]    cfg_tg_x_log_i;
  logic [2:0]    cfg_tg_y_log_i;
  logic [6:0]    cfg_origin_x_i;
  logic [6:0]    cfg_origin_y_i;
  logic          v_i;
  logic          ready_o;
  logic [31:0]   eva_i;
  logic [3:0]    hash_i;
  logic          v_o;
  logic          ready_i;
  logic [6:0]    x_o;
  logic [6:0]    y_o;
  logic [15:0]   addr_o;
  logic          err_o;
  logic [CW-1:0] req_count_o;
  logic [CW-1:0] err_count_o;

  always #5 clk = ~clk;

  hash_function_shared_pipe #(.count_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o),
    .cfg_tg_x_log_i(cfg_tg_x_log_i), .cfg_tg_y_log_i(cfg_tg_y_log_i),
    .cfg_origin_x_i(cfg_origin_x_i), .cfg_origin_y_i(cfg_origin_y_i),
    .v_i(v_i), .ready_o(ready_o), .eva_i(eva_i), .hash_i(hash_i),
    .v_o(v_o), .ready_i(ready_i), .x_o(x_o), .y_o(y_o), .addr_o(addr_o),
    .err_o(err_o), .req_count_o(req_count_o), .err_count_o(err_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_req  = 0;
  int exp_err  = 0;

  // Stream vectors: config tx=2, ty=1, origin (4,2), hash=2.
  logic [31:0] tab_eva  [8];
  logic [6:0]  tab_x    [8];
  logic [6:0]  tab_y    [8];
  logic [15:0] tab_addr [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [2:0] tx, input logic [2:0] ty,
                           input logic [6:0] ox, input logic [6:0] oy);
    cfg_v_i = 1'b1; cfg_tg_x_log_i = tx; cfg_tg_y_log_i = ty;
    cfg_origin_x_i = ox; cfg_origin_y_i = oy;
    @(negedge clk);
    check_eq("cfg_ready_idle", 32'(cfg_ready_o), 32'd1);
    tick();
    cfg_v_i = 1'b0;
  endtask

  // Send one request into an empty pipe, check 2-cycle latency and result.
  task automatic send_one(input string tag, input logic [31:0] eva, input logic [3:0] h,
                          input logic [6:0] ex, input logic [6:0] ey,
                          input logic [15:0] ea, input logic ee);
    int hs;
    bit got;
    hs = -1; got = 1'b0;
    v_i = 1'b1; eva_i = eva; hash_i = h; ready_i = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (v_o) begin
        got = 1'b1;
        check_eq({tag, "_lat"}, 32'(c - hs), 32'd2);
        check_eq({tag, "_x"}, 32'(x_o), 32'(ex));
        check_eq({tag, "_y"}, 32'(y_o), 32'(ey));
        check_eq({tag, "_addr"}, 32'(addr_o), 32'(ea));
        check_eq({tag, "_err"}, 32'(err_o), 32'(ee));
        $display("txn %s eva=%08h h=%0d -> x=%0d y=%0d addr=%04h err=%0d",
                 tag, eva, h, x_o, y_o, addr_o, err_o);
      end
      if (v_i && ready_o) begin
        hs = c;
        exp_req = sat_inc(exp_req);
        if (ee) exp_err = sat_inc(exp_err);
      end
      tick();
      if (hs >= 0) v_i = 1'b0;
    end
    if (!got) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    v_i = 1'b0;
  endtask

  // Stream n table entries back to back, dropping ready_i for stall_len
  // cycles from cycle stall_start.
  task automatic run_stream(input string tag, input int n, input int stall_start, input int stall_len);
    int idx_in, idx_out, cyc, first_hs, first_out, last_out;
    idx_in = 0; idx_out = 0; cyc = 0; first_hs = -1; first_out = -1; last_out = -1;
    while (idx_out < n && cyc < 200) begin
      v_i     = (idx_in < n);
      eva_i   = (idx_in < n) ? tab_eva[idx_in] : 32'd0;
      hash_i  = 4'd2;
      ready_i = !(cyc >= stall_start && cyc < stall_start + stall_len);
      @(negedge clk);
      if (v_o && !ready_i) begin
        check_eq({tag, "_stall_ready"}, 32'(ready_o), 32'd0);
        check_eq({tag, "_hold_x"}, 32'(x_o), 32'(tab_x[idx_out]));
        check_eq({tag, "_hold_addr"}, 32'(addr_o), 32'(tab_addr[idx_out]));
      end
      if (v_o && ready_i) begin
        check_eq({tag, "_x"}, 32'(x_o), 32'(tab_x[idx_out]));
        check_eq({tag, "_y"}, 32'(y_o), 32'(tab_y[idx_out]));
        check_eq({tag, "_addr"}, 32'(addr_o), 32'(tab_addr[idx_out]));
        check_eq({tag, "_err"}, 32'(err_o), 32'd0);
        $display("txn %s #%0d x=%0d y=%0d addr=%04h", tag, idx_out, x_o, y_o, addr_o);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        idx_out++;
      end
      if (v_i && ready_o) begin
        if (first_hs < 0) first_hs = cyc;
        exp_req = sat_inc(exp_req);
        idx_in++;
      end
      tick();
      cyc++;
    end
    check_eq({tag, "_count_out"}, 32'(idx_out), 32'(n));
    if (stall_len == 0) begin
      check_eq({tag, "_first_lat"}, 32'(first_out - first_hs), 32'd2);
      check_eq({tag, "_consec"}, 32'(last_out - first_out), 32'(n - 1));
    end
    v_i = 1'b0;
    @(negedge clk);
    check_eq({tag, "_no_dup"}, 32'(v_o), 32'd0);
    tick();
  endtask

  initial begin
    bit seen;
    tab_eva[0] = 32'h000; tab_x[0] = 7'd4; tab_y[0] = 7'd2; tab_addr[0] = 16'h0000;
    tab_eva[1] = 32'h001; tab_x[1] = 7'd4; tab_y[1] = 7'd2; tab_addr[1] = 16'h0001;
    tab_eva[2] = 32'h004; tab_x[2] = 7'd5; tab_y[2] = 7'd2; tab_addr[2] = 16'h0000;
    tab_eva[3] = 32'h00C; tab_x[3] = 7'd7; tab_y[3] = 7'd2; tab_addr[3] = 16'h0000;
    tab_eva[4] = 32'h010; tab_x[4] = 7'd4; tab_y[4] = 7'd3; tab_addr[4] = 16'h0000;
    tab_eva[5] = 32'h020; tab_x[5] = 7'd4; tab_y[5] = 7'd2; tab_addr[5] = 16'h0004;
    tab_eva[6] = 32'h03F; tab_x[6] = 7'd7; tab_y[6] = 7'd3; tab_addr[6] = 16'h0007;
    tab_eva[7] = 32'hFFE; tab_x[7] = 7'd7; tab_y[7] = 7'd3; tab_addr[7] = 16'h01FE;

    reset_i = 1'b1; cfg_v_i = 1'b0; v_i = 1'b0; ready_i = 1'b1;
    eva_i = '0; hash_i = '0;
    cfg_tg_x_log_i = '0; cfg_tg_y_log_i = '0; cfg_origin_x_i = '0; cfg_origin_y_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_v_o", 32'(v_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_x", 32'(x_o), 32'd0);
    check_eq("rst_y", 32'(y_o), 32'd0);
    check_eq("rst_addr", 32'(addr_o), 32'd0);
    check_eq("rst_req_cnt", 32'(req_count_o), 32'd0);
    check_eq("rst_err_cnt", 32'(err_count_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(ready_o), 32'd1);
    check_eq("idle_cfg_ready", 32'(cfg_ready_o), 32'd1);
    tick();

    // Config write with a simultaneous request: config wins
    cfg_v_i = 1'b1; cfg_tg_x_log_i = 3'd2; cfg_tg_y_log_i = 3'd1;
    cfg_origin_x_i = 7'd4; cfg_origin_y_i = 7'd2;
    v_i = 1'b1; eva_i = 32'hB7; hash_i = 4'd2;
    @(negedge clk);
    check_eq("cfg_prio_ready", 32'(ready_o), 32'd0);
    check_eq("cfg_prio_cfg_ready", 32'(cfg_ready_o), 32'd1);
    tick();
    cfg_v_i = 1'b0; v_i = 1'b0;

    send_one("basic", 32'hB7, 4'd2, 7'd5, 7'd3, 16'h0017, 1'b0);
    @(negedge clk);
    check_eq("basic_req_cnt", 32'(req_count_o), 32'd1);
    tick();

    // Fresh start so the stream count stands alone
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    exp_req = 0; exp_err = 0;
    write_cfg(3'd2, 3'd1, 7'd4, 7'd2);

    run_stream("stream", 8, 1000, 0);
    @(negedge clk);
    check_eq("stream_req_cnt", 32'(req_count_o), 32'd8);
    tick();

    run_stream("bp", 8, 4, 5);

    send_one("err", 32'hFFFF_FFFF, 4'd13, 7'd0, 7'd0, 16'h0000, 1'b1);
    @(negedge clk);
    check_eq("err_cnt", 32'(err_count_o), 32'd1);
    tick();
    send_one("h12", 32'h0000_F123, 4'd12, 7'd7, 7'd3, 16'h1123, 1'b0);
    send_one("legal", 32'hB7, 4'd2, 7'd5, 7'd3, 16'h0017, 1'b0);

    // Config ordering: request held in the pipe, config write waits
    ready_i = 1'b0; v_i = 1'b1; eva_i = 32'hB7; hash_i = 4'd2;
    @(negedge clk);
    check_eq("ord_accept", 32'(ready_o), 32'd1);
    if (ready_o) exp_req = sat_inc(exp_req);
    tick();
    v_i = 1'b0;
    cfg_v_i = 1'b1; cfg_tg_x_log_i = 3'd2; cfg_tg_y_log_i = 3'd1;
    cfg_origin_x_i = 7'd127; cfg_origin_y_i = 7'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("ord_cfg_blocked", 32'(cfg_ready_o), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    @(negedge clk);
    check_eq("ord_drain_v", 32'(v_o), 32'd1);
    check_eq("ord_drain_x", 32'(x_o), 32'd5);
    check_eq("ord_drain_y", 32'(y_o), 32'd3);
    check_eq("ord_drain_addr", 32'(addr_o), 32'h17);
    check_eq("ord_drain_cfg_ready", 32'(cfg_ready_o), 32'd0);
    tick();
    v_i = 1'b1; eva_i = 32'h08;
    @(negedge clk);
    check_eq("ord_cfg_ready", 32'(cfg_ready_o), 32'd1);
    check_eq("ord_req_blocked", 32'(ready_o), 32'd0);
    tick();
    cfg_v_i = 1'b0;

    // Uses the new origin (127,0): X field 2 wraps to 1
    send_one("wrap", 32'h08, 4'd2, 7'd1, 7'd0, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("mid_req_cnt", 32'(req_count_o), 32'(exp_req));
    check_eq("mid_err_cnt", 32'(err_count_o), 32'(exp_err));
    tick();

    // Saturation: flood with erroring requests
    v_i = 1'b1; eva_i = 32'd0; hash_i = 4'd13; ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) begin
        exp_req = sat_inc(exp_req);
        exp_err = sat_inc(exp_err);
      end
      tick();
    end
    v_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("sat_req_cnt", 32'(req_count_o), 32'(exp_req));
    check_eq("sat_err_cnt", 32'(err_count_o), 32'(exp_err));
    check_eq("sat_req_max", 32'(req_count_o), 32'(CNT_MAX));
    tick();

    // Asynchronous reset mid-stream
    v_i = 1'b1; eva_i = 32'h3F; hash_i = 4'd2; ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (v_o) seen = 1'b1;
      else tick();
    end
    check_eq("arst_pre_v", 32'(seen), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    check_eq("arst_v_drop", 32'(v_o), 32'd0);
    check_eq("arst_req_cnt", 32'(req_count_o), 32'd0);
    v_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check_eq("arst_no_replay", 32'(v_o), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
